// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_STALL,
    S_DROP
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/if_fetch_skid.sv
// IF/ID output register plus one skid entry that absorbs a fetch landing while the consumer is frozen.
module if_fetch_skid #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         skid_load_i,
  input  logic         pop_i,
  input  logic         accept_i,
  input  logic [W-1:0] pc_i,
  input  logic [W-1:0] instr_i,
  output logic         valid_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] instr_o
);

  logic         skid_vld_q;
  logic [W-1:0] skid_pc_q;
  logic [W-1:0] skid_instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o      <= 1'b0;
      pc_o         <= '0;
      instr_o      <= '0;
      skid_vld_q   <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else if (clear_i) begin
      valid_o    <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      if (load_i) begin
        valid_o <= 1'b1;
        pc_o    <= pc_i;
        instr_o <= instr_i;
      end else if (pop_i && skid_vld_q) begin
        // Consumer took the out entry this edge; the skid entry moves up.
        pc_o       <= skid_pc_q;
        instr_o    <= skid_instr_q;
        skid_vld_q <= 1'b0;
      end else if (accept_i) begin
        valid_o <= 1'b0;
      end
      if (skid_load_i) begin
        skid_vld_q   <= 1'b1;
        skid_pc_q    <= pc_i;
        skid_instr_q <= instr_i;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC, imem req/ready handshake, freeze and branch redirect.
// Optional IF_FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter int unsigned           BIT_NUMBER = 32,
  parameter logic [BIT_NUMBER-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [BIT_NUMBER-1:0] branch_addr,
  output logic                  imem_req,
  output logic [BIT_NUMBER-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [BIT_NUMBER-1:0] imem_rdata,
  output logic [BIT_NUMBER-1:0] pc_out,
  output logic [BIT_NUMBER-1:0] instruction_out,
  output logic                  valid_out,
  output logic                  flush_out
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubbles
`endif
);

  fetch_state_e          state_q, state_d;
  logic [BIT_NUMBER-1:0] pc_q, pc_d;
  logic [BIT_NUMBER-1:0] target_q, target_d;
  logic [BIT_NUMBER-1:0] pc_inc;
  logic                  req_q;
  logic                  ld_out, ld_skid, pop, clr, accept;

  assign pc_inc    = pc_q + BIT_NUMBER'(INSTR_BYTES);
  assign accept    = valid_out && !freeze;
  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign flush_out = branch_taken;

  // Next-state and buffer control; branch_taken outranks freeze and ready.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    ld_out   = 1'b0;
    ld_skid  = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_ISSUE;
        if (branch_taken) begin
          clr  = 1'b1;
          pc_d = branch_addr;
        end
      end
      S_ISSUE: begin
        if (branch_taken) begin
          clr      = 1'b1;
          target_d = branch_addr;
          if (imem_ready) pc_d = branch_addr;
          else            state_d = S_DROP;
        end else if (imem_ready) begin
          pc_d = pc_inc;
          if (!valid_out || !freeze) begin
            ld_out = 1'b1;
          end else begin
            ld_skid = 1'b1;
            state_d = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (branch_taken) begin
          clr     = 1'b1;
          pc_d    = branch_addr;
          state_d = S_ISSUE;
        end else if (!freeze) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DROP: begin
        if (branch_taken) begin
          clr      = 1'b1;
          target_d = branch_addr;
        end
        if (imem_ready) begin
          pc_d    = branch_taken ? branch_addr : target_q;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      target_q <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      req_q    <= (state_d == S_ISSUE) || (state_d == S_DROP);
    end
  end

  if_fetch_skid #(.W(BIT_NUMBER)) u_skid (
    .clk        (clk),
    .rst_n      (rst),
    .clear_i    (clr),
    .load_i     (ld_out),
    .skid_load_i(ld_skid),
    .pop_i      (pop),
    .accept_i   (accept),
    .pc_i       (pc_inc),
    .instr_i    (imem_rdata),
    .valid_o    (valid_out),
    .pc_o       (pc_out),
    .instr_o    (instruction_out)
  );

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (accept)                 perf_fetched <= perf_fetched + 32'd1;
      if (!valid_out && !freeze)  perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule
